store_buffer: RTL and testbench

//  Posted-write FIFO between the CPU load/store path and the byte-addressed data memory.

---
 rtl/store_buffer.sv | 196 +++++++++++++++++++
 tb/tb_store_buffer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//   Posted-write FIFO between the CPU load/store path and a byte-addressed
//   data memory. Stores retire into the buffer in one cycle and drain to memory
//   one per cycle in program order. Loads share the single memory port. A load
//   that hits a pending store (same word) stalls until every matching entry has
//   drained. A flush request drains the whole buffer and reports completion with
//   a one-cycle pulse.
//
//   Optional feature: define STORE_FWD_EN to forward pending store data to
//   hitting loads when the youngest matching entry fully covers the load.
//
// Ports
//   clk_i, rst_i                    clock, synchronous active-high reset
//   st_valid_i/st_ready_o           store handshake (ready = not full, not flushing)
//   st_byte_i/st_addr_i/st_wd_i     store kind (1 = SB), address, data
//   ld_valid_i/ld_byte_i/ld_addr_i  load request (ld_byte_i 1 = LBU)
//   ld_stall_o/ld_rd_o              load stall and load data
//   flush_i/flush_done_o            drain-all request and completion pulse
//   empty_o                         no pending stores
//   mem_we_o/mem_byte_op_o          memory write enable and byte-op select
//   mem_addr_o/mem_wd_o/mem_rd_i    memory address, write data, read data
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  st_valid_i,
    output logic                  st_ready_o,
    input  logic                  st_byte_i,
    input  logic [DATA_WIDTH-1:0] st_addr_i,
    input  logic [DATA_WIDTH-1:0] st_wd_i,
    input  logic                  ld_valid_i,
    input  logic                  ld_byte_i,
    input  logic [DATA_WIDTH-1:0] ld_addr_i,
    output logic                  ld_stall_o,
    output logic [DATA_WIDTH-1:0] ld_rd_o,
    input  logic                  flush_i,
    output logic                  flush_done_o,
    output logic                  empty_o,
    output logic                  mem_we_o,
    output logic                  mem_byte_op_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wd_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_i
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    // Byte-offset bits within a word; hits compare everything above them.
    localparam int OFS_W = $clog2(DATA_WIDTH / BYTE_WIDTH);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t                state;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      count;
    logic [PTR_W-1:0]      count_next;
    logic [IDX_W-1:0]      rd_idx;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      scan_idx;

    logic                  ent_byte [DEPTH];
    logic [DATA_WIDTH-1:0] ent_addr [DEPTH];
    logic [DATA_WIDTH-1:0] ent_wd   [DEPTH];

    logic                  empty;
    logic                  full;
    logic                  hit;
    logic                  load_port;
    logic                  pop;
    logic                  push;
    logic                  fwd_ok;
    logic [DATA_WIDTH-1:0] fwd_data;

    assign rd_idx = rd_ptr[IDX_W-1:0];
    assign wr_idx = wr_ptr[IDX_W-1:0];
    assign count  = wr_ptr - rd_ptr;
    assign empty  = (wr_ptr == rd_ptr);
    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full   = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) && (wr_idx == rd_idx);

`ifdef STORE_FWD_EN
    logic [IDX_W-1:0] yng_idx;
`endif

    // Scan oldest to youngest so the last match is the youngest entry.
    always_comb begin
        hit      = 1'b0;
        scan_idx = rd_idx;
`ifdef STORE_FWD_EN
        yng_idx  = rd_idx;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = rd_idx + IDX_W'(k);
            if ((PTR_W'(k) < count) &&
                (ent_addr[scan_idx][DATA_WIDTH-1:OFS_W] == ld_addr_i[DATA_WIDTH-1:OFS_W])) begin
                hit = 1'b1;
`ifdef STORE_FWD_EN
                yng_idx = scan_idx;
`endif
            end
        end
    end

`ifdef STORE_FWD_EN
    function automatic logic [DATA_WIDTH-1:0] select_byte(input logic [DATA_WIDTH-1:0] word,
                                                           input logic [OFS_W-1:0]      lane);
        logic [DATA_WIDTH-1:0] shifted;
        shifted = word >> (lane * BYTE_WIDTH);
        return DATA_WIDTH'(shifted[BYTE_WIDTH-1:0]);
    endfunction

    // Forward only when the youngest match covers every byte the load reads.
    always_comb begin
        fwd_ok   = 1'b0;
        fwd_data = '0;
        if (hit && (state == RUN) && !full) begin
            if (!ent_byte[yng_idx]) begin
                fwd_ok   = 1'b1;
                fwd_data = ld_byte_i ? select_byte(ent_wd[yng_idx], ld_addr_i[OFS_W-1:0])
                                     : ent_wd[yng_idx];
            end else if (ld_byte_i && (ent_addr[yng_idx] == ld_addr_i)) begin
                fwd_ok   = 1'b1;
                fwd_data = select_byte(ent_wd[yng_idx], '0);
            end
        end
    end
`else
    assign fwd_ok   = 1'b0;
    assign fwd_data = '0;
`endif

    // Port arbitration: a clean load wins unless the buffer is full or flushing.
    assign load_port  = (state == RUN) && ld_valid_i && !hit && !full;
    assign pop        = !empty && ((state == FLUSH) || !load_port);
    assign st_ready_o = (state == RUN) && !full;
    assign push       = st_valid_i && st_ready_o;
    assign count_next = count + PTR_W'(push) - PTR_W'(pop);

    assign ld_stall_o = ld_valid_i && ((hit && !fwd_ok) || full || (state == FLUSH));
    assign ld_rd_o    = fwd_ok ? fwd_data : mem_rd_i;
    assign empty_o    = empty;

    assign mem_we_o      = pop;
    assign mem_byte_op_o = pop ? ent_byte[rd_idx] : ld_byte_i;
    assign mem_addr_o    = pop ? ent_addr[rd_idx] : ld_addr_i;
    assign mem_wd_o      = ent_wd[rd_idx];

    // Control state: pointers, FSM and the completion pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            state        <= RUN;
            flush_done_o <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            flush_done_o <= 1'b0;
            case (state)
                RUN: begin
                    // A flush that empties the buffer in its own cycle completes at once.
                    if (flush_i) begin
                        if (empty || (count_next == '0)) flush_done_o <= 1'b1;
                        else                             state        <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (count_next == '0) begin
                        state        <= RUN;
                        flush_done_o <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Entry payload: no reset, contents only matter between push and pop.
    always_ff @(posedge clk_i) begin
        if (push) begin
            ent_byte[wr_idx] <= st_byte_i;
            ent_addr[wr_idx] <= st_addr_i;
            ent_wd[wr_idx]   <= st_wd_i;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          st_valid_i = 1'b0;
    logic          st_ready_o;
    logic          st_byte_i = 1'b0;
    logic [DW-1:0] st_addr_i = 32'h10000;
    logic [DW-1:0] st_wd_i = '0;
    logic          ld_valid_i = 1'b0;
    logic          ld_byte_i = 1'b0;
    logic [DW-1:0] ld_addr_i = 32'h10000;
    logic          ld_stall_o;
    logic [DW-1:0] ld_rd_o;
    logic          flush_i = 1'b0;
    logic          flush_done_o;
    logic          empty_o;
    logic          mem_we_o;
    logic          mem_byte_op_o;
    logic [DW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wd_o;
    logic [DW-1:0] mem_rd_i;

    always #5 clk = ~clk;

    store_buffer #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .st_valid_i(st_valid_i), .st_ready_o(st_ready_o), .st_byte_i(st_byte_i),
        .st_addr_i(st_addr_i), .st_wd_i(st_wd_i),
        .ld_valid_i(ld_valid_i), .ld_byte_i(ld_byte_i), .ld_addr_i(ld_addr_i),
        .ld_stall_o(ld_stall_o), .ld_rd_o(ld_rd_o),
        .flush_i(flush_i), .flush_done_o(flush_done_o), .empty_o(empty_o),
        .mem_we_o(mem_we_o), .mem_byte_op_o(mem_byte_op_o), .mem_addr_o(mem_addr_o),
        .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i)
    );

    // Data memory seen by the DUT: 16 words at 0x10000, combinational read,
    // write on the negative edge.
    bit   [31:0] mem [16];
    logic [31:0] mem_word;

    always @(negedge clk) begin
        if (mem_we_o === 1'b1) begin
            if (mem_byte_op_o) mem[mem_addr_o[5:2]][mem_addr_o[1:0]*8 +: 8] <= mem_wd_o[7:0];
            else               mem[mem_addr_o[5:2]] <= mem_wd_o;
        end
    end

    always_comb begin
        mem_word = mem[mem_addr_o[5:2]];
        mem_rd_i = mem_byte_op_o ? {24'b0, mem_word[mem_addr_o[1:0]*8 +: 8]} : mem_word;
    end

    // Reference model: ordered queue of pending stores plus a memory image
    // updated in program order as stores retire.
    typedef struct packed {
        bit        b;
        bit [31:0] a;
        bit [31:0] d;
    } st_t;

    st_t       q[$];
    bit [31:0] ref_mem [16];
    bit        flushing = 1'b0;
    bit        done_pend = 1'b0;

    int        checks = 0;
    int        errors = 0;
    bit        last_acc;
    bit        last_stall;
    logic [31:0] last_rd;

    function automatic bit [31:0] ref_read(input bit [31:0] a, input bit b);
        bit [31:0] w;
        w = ref_mem[a[5:2]];
        return b ? {24'b0, w[a[1:0]*8 +: 8]} : w;
    endfunction

    function automatic void ref_write(input st_t s);
        if (s.b) ref_mem[s.a[5:2]][s.a[1:0]*8 +: 8] = s.d[7:0];
        else     ref_mem[s.a[5:2]] = s.d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic cycle(input bit rst, input bit sv, input bit sb, input bit [31:0] sa,
                         input bit [31:0] sd, input bit lv, input bit lb, input bit [31:0] la,
                         input bit fl);
        int        n;
        bit        full, emp, hit, fwd, lport, pop, exp_stall, exp_ready, nd;
        bit [31:0] fv;
        st_t       y;
        rst_i = rst; st_valid_i = sv; st_byte_i = sb; st_addr_i = sa; st_wd_i = sd;
        ld_valid_i = lv; ld_byte_i = lb; ld_addr_i = la; flush_i = fl;
        #2;
        n = q.size(); full = (n == DEPTH); emp = (n == 0);
        hit = 1'b0; fwd = 1'b0; fv = '0; y = '0;
        foreach (q[i]) if (q[i].a[31:2] == la[31:2]) begin hit = 1'b1; y = q[i]; end
`ifdef STORE_FWD_EN
        if (hit && !flushing && !full) begin
            if (!y.b) begin
                fwd = 1'b1;
                fv  = lb ? ((y.d >> (8 * la[1:0])) & 32'hFF) : y.d;
            end else if (lb && y.a == la) begin
                fwd = 1'b1;
                fv  = {24'b0, y.d[7:0]};
            end
        end
`endif
        lport     = !flushing && lv && !hit && !full;
        pop       = !emp && (flushing || !lport);
        exp_stall = lv && (flushing || full || (hit && !fwd));
        exp_ready = !flushing && !full;

        chk("st_ready", st_ready_o, exp_ready);
        chk("empty", empty_o, emp);
        chk("flush_done", flush_done_o, done_pend);
        chk("mem_we", mem_we_o, pop);
        chk("ld_stall", ld_stall_o, exp_stall);
        if (pop) begin
            chk("drain_addr", mem_addr_o, q[0].a);
            chk("drain_wd", mem_wd_o, q[0].d);
            chk("drain_byte", mem_byte_op_o, q[0].b);
        end else if (lport) begin
            chk("load_addr", mem_addr_o, la);
            chk("load_byte", mem_byte_op_o, lb);
        end
        if (lv && !exp_stall) chk("ld_rd", ld_rd_o, fwd ? fv : ref_read(la, lb));
        last_acc = sv && exp_ready; last_stall = exp_stall; last_rd = ld_rd_o;

        if (pop) begin ref_write(q[0]); void'(q.pop_front()); end
        if (rst) begin
            q.delete(); flushing = 1'b0; done_pend = 1'b0;
        end else begin
            if (last_acc) q.push_back('{sb, sa, sd});
            nd = 1'b0;
            if (!flushing) begin
                if (fl) begin
                    if (emp || q.size() == 0) nd = 1'b1;
                    else                      flushing = 1'b1;
                end
            end else if (q.size() == 0) begin
                flushing = 1'b0; nd = 1'b1;
            end
            done_pend = nd;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 32'h10000, 0, 0, 0, 32'h10000, 0);
    endtask

    // Store that retries until accepted, with an optional load held alongside.
    task automatic store(input bit sb, input bit [31:0] sa, input bit [31:0] sd,
                         input bit lv, input bit [31:0] la);
        int tries = 0;
        do begin
            cycle(0, 1, sb, sa, sd, lv, 0, la, 0);
            tries++;
        end while (!last_acc && tries < 20);
        chk("store_accept", last_acc, 1'b1);
    endtask

    // Load held until served.
    task automatic load(input bit lb, input bit [31:0] la);
        int tries = 0;
        do begin
            cycle(0, 0, 0, 32'h10000, 0, 1, lb, la, 0);
            tries++;
        end while (last_stall && tries < 20);
        chk("load_served", last_stall, 1'b0);
    endtask

    initial begin
        // Unchecked power-up reset while DUT state is unknown.
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Reset state.
        idle(1);

        // Single SW drains next cycle.
        store(0, 32'h10000, 32'hDEADBEEF, 0, 32'h10000);
        chk("t1_we", mem_we_o, 1'b1);
        chk("t1_addr", mem_addr_o, 32'h10000);
        chk("t1_wd", mem_wd_o, 32'hDEADBEEF);
        idle(2);

        // DEPTH+1 stores behind a non-hitting load: fill, stall, drain, order.
        store(0, 32'h10010, 32'hAAAA0001, 1, 32'h1003C);
        store(0, 32'h10014, 32'hBBBB0002, 1, 32'h1003C);
        store(0, 32'h10010, 32'hCCCC0003, 1, 32'h1003C);
        store(0, 32'h10018, 32'hDDDD0004, 1, 32'h1003C);
        store(0, 32'h10014, 32'hEEEE0005, 1, 32'h1003C);
        idle(6);
        load(0, 32'h10010);
        chk("t2_order_a", last_rd, 32'hCCCC0003);
        load(0, 32'h10014);
        chk("t2_order_b", last_rd, 32'hEEEE0005);

        // SB pending, LW to the same word stalls then sees the byte.
        store(1, 32'h10023, 32'h000000AB, 0, 32'h10000);
        load(0, 32'h10020);
        chk("t3_byte", last_rd[31:24], 8'hAB);
        idle(2);

`ifdef STORE_FWD_EN
        // Word store forwarded to LBU of its byte 2.
        store(0, 32'h10004, 32'h11223344, 0, 32'h10000);
        cycle(0, 0, 0, 32'h10000, 0, 1, 1, 32'h10006, 0);
        chk("t4_stall", last_stall, 1'b0);
        chk("t4_rd", last_rd, 32'h00000022);
        idle(2);
`endif

        // Three pending stores then a flush, with stores attempted during it.
        store(0, 32'h10024, 32'h01010101, 1, 32'h1003C);
        store(1, 32'h10029, 32'h00000055, 1, 32'h1003C);
        store(0, 32'h1002C, 32'h03030303, 1, 32'h1003C);
        cycle(0, 0, 0, 32'h10000, 0, 0, 0, 32'h10000, 1);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 32'h10030, 32'h77777777, 1, 0, 32'h10024, 0);
        idle(2);
        // Flush of an empty buffer pulses next cycle.
        cycle(0, 0, 0, 32'h10000, 0, 0, 0, 32'h10000, 1);
        chk("t5_empty_done", flush_done_o, 1'b1);
        idle(2);

        // Reset with entries pending discards them.
        store(0, 32'h10030, 32'h0A0A0A0A, 1, 32'h1003C);
        store(0, 32'h10034, 32'h0B0B0B0B, 1, 32'h1003C);
        store(0, 32'h10038, 32'h0C0C0C0C, 1, 32'h1003C);
        cycle(1, 0, 0, 32'h10000, 0, 1, 0, 32'h1003C, 0);
        idle(3);

        // Randomized traffic over a few words so hits are frequent.
        for (int i = 0; i < 1500; i++) begin
            bit        r_rst, r_sv, r_sb, r_lv, r_lb, r_fl;
            bit [31:0] r_sa, r_la, r_sd;
            r_rst = ($urandom_range(0, 99) == 0);
            r_fl  = ($urandom_range(0, 19) == 0);
            r_sv  = $urandom_range(0, 1);
            r_sb  = $urandom_range(0, 1);
            r_lv  = $urandom_range(0, 1);
            r_lb  = $urandom_range(0, 1);
            r_sa  = 32'h10000 + 32'($urandom_range(0, 5)) * 4 + 32'($urandom_range(0, 3));
            r_la  = 32'h10000 + 32'($urandom_range(0, 5)) * 4 + 32'($urandom_range(0, 3));
            r_sd  = $urandom;
            cycle(r_rst, r_sv, r_sb, r_sa, r_sd, r_lv, r_lb, r_la, r_fl);
        end
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
